// File: rtl/ga23_pkg.sv
// rtl/ga23_pkg.sv - shared GA23 SDRAM arbiter types and constants
package ga23_pkg;

    localparam int GA23_SDR_ADDR_W = 21;
    localparam int GA23_SDR_DATA_W = 32;
    localparam int GA23_NUM_LAYERS = 3;

    // The issue cycle lives inside the IDLE->WAIT transition, so two states suffice.
    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ga23_rr_pick.sv
// rtl/ga23_rr_pick.sv - combinational round-robin picker, first request at or after ptr
module ga23_rr_pick
    import ga23_pkg::*;
#(
    parameter int N  = GA23_NUM_LAYERS,
    parameter int PW = ptr_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] gnt,
    output logic          any
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        gnt = '0;
        any = 1'b0;
        idx = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (req[idx]) begin
                gnt = PW'(idx);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ga23_sdr_arbiter.sv
// rtl/ga23_sdr_arbiter.sv - round-robin serialiser of layer row fetches onto one SDRAM read channel
module ga23_sdr_arbiter
    import ga23_pkg::*;
#(
    parameter int NUM_LAYERS = GA23_NUM_LAYERS,
    parameter int ADDR_W     = GA23_SDR_ADDR_W,
    parameter int DATA_W     = GA23_SDR_DATA_W,
    parameter int TIMEOUT    = 64
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_LAYERS-1:0]        layer_req,
    input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
    output logic [NUM_LAYERS*DATA_W-1:0] layer_data,
    output logic [NUM_LAYERS-1:0]        layer_rdy,
    output logic [NUM_LAYERS-1:0]        layer_err,
    output logic                         mem_req,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic                         mem_rdy,
    input  logic [DATA_W-1:0]            mem_data,
    output logic                         busy
);

    localparam int PW = ptr_w(NUM_LAYERS);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t              state;
    logic [NUM_LAYERS-1:0]   pend;
    logic [ADDR_W-1:0]       pend_addr [NUM_LAYERS];
    logic [ADDR_W-1:0]       pick_addr;
    logic [PW-1:0]           rr_ptr;
    logic [PW-1:0]           gnt;
    logic [PW-1:0]           pick;
    logic [PW-1:0]           rr_next;
    logic                    pick_any;
    logic                    issue;
    logic [CW-1:0]           cnt;

    ga23_rr_pick #(.N(NUM_LAYERS), .PW(PW)) u_pick (
        .req (pend),
        .ptr (rr_ptr),
        .gnt (pick),
        .any (pick_any)
    );

    assign issue   = (state == ARB_IDLE) && pick_any;
    assign busy    = (state == ARB_WAIT);
    assign rr_next = (gnt == PW'(NUM_LAYERS - 1)) ? '0 : gnt + 1'b1;

    always_comb begin
        pick_addr = '0;
        for (int i = 0; i < NUM_LAYERS; i++)
            if (pick == PW'(i)) pick_addr = pend_addr[i];
    end

    // A request landing in the issue cycle re-arms the slot with its new address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend <= '0;
            for (int i = 0; i < NUM_LAYERS; i++) pend_addr[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (layer_req[i]) begin
                    pend[i]      <= 1'b1;
                    pend_addr[i] <= layer_addr[i*ADDR_W +: ADDR_W];
                end else if (issue && (pick == PW'(i))) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARB_IDLE;
            rr_ptr     <= '0;
            gnt        <= '0;
            cnt        <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            layer_data <= '0;
            layer_rdy  <= '0;
            layer_err  <= '0;
        end else begin
            mem_req   <= 1'b0;
            layer_rdy <= '0;
            layer_err <= '0;
            case (state)
                ARB_IDLE: begin
                    cnt <= '0;
                    if (pick_any) begin
                        mem_req  <= 1'b1;
                        mem_addr <= pick_addr;
                        gnt      <= pick;
                        state    <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (mem_rdy) begin
                        for (int i = 0; i < NUM_LAYERS; i++) begin
                            if (gnt == PW'(i)) begin
                                layer_data[i*DATA_W +: DATA_W] <= mem_data;
                                layer_rdy[i]                   <= 1'b1;
                            end
                        end
                        rr_ptr <= rr_next;
                        state  <= ARB_IDLE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        for (int i = 0; i < NUM_LAYERS; i++)
                            if (gnt == PW'(i)) layer_err[i] <= 1'b1;
                        rr_ptr <= rr_next;
                        state  <= ARB_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ga23_sdr_arbiter.sv
// tb/tb_ga23_sdr_arbiter.sv - scoreboard bench for ga23_sdr_arbiter
module tb_ga23_sdr_arbiter;

    localparam int NL = 3;
    localparam int AW = 21;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NL-1:0]    layer_req;
    logic [NL*AW-1:0] layer_addr;
    logic [NL*DW-1:0] layer_data;
    logic [NL-1:0]    layer_rdy;
    logic [NL-1:0]    layer_err;
    logic             mem_req;
    logic [AW-1:0]    mem_addr;
    logic             mem_rdy;
    logic [DW-1:0]    mem_data;
    logic             busy;

    always #5 clk = ~clk;

    ga23_sdr_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .layer_req  (layer_req),
        .layer_addr (layer_addr),
        .layer_data (layer_data),
        .layer_rdy  (layer_rdy),
        .layer_err  (layer_err),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdy    (mem_rdy),
        .mem_data   (mem_data),
        .busy       (busy)
    );

    typedef struct {
        int            layer;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            err;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model_data [NL];
    int            n_cmp = 0;
    int            n_err = 0;

    function automatic logic [NL*DW-1:0] model_packed();
        logic [NL*DW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*DW +: DW] = model_data[i];
        return r;
    endfunction

    task automatic push_exp(input int l, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit e);
        exp_t x;
        x.layer = l; x.addr = a; x.data = d; x.err = e;
        sb.push_back(x);
    endtask

    task automatic drive_req(input logic [NL-1:0] mask, input logic [AW-1:0] a0, a1, a2);
        @(posedge clk); #1;
        layer_req  = mask;
        layer_addr = {a2, a1, a0};
        @(posedge clk); #1;
        layer_req  = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < NL; i++) model_data[i] = '0;
    endtask

    task automatic wait_req(output bit seen, output int cyc);
        seen = 1'b0;
        cyc  = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                seen = 1'b1;
                cyc  = i;
                break;
            end
        end
    endtask

    // Scoreboard consumer: next expected fetch must appear on mem_*, then its result on layer_*.
    task automatic serve_one(input int lat, output int cyc);
        exp_t e;
        bit   seen;
        int   k;
        cyc = 0;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: got no expected entry, required one");
            return;
        end
        e = sb.pop_front();
        wait_req(seen, cyc);
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL mem_req_seen: got none within 200 cycles, required addr %h", e.addr);
            return;
        end
        n_cmp++;
        if (mem_addr !== e.addr) begin
            n_err++;
            $display("FAIL mem_addr: got %h required %h", mem_addr, e.addr);
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_on_issue: got %b required 1", busy);
        end
        if (!e.err) begin
            repeat (lat) @(posedge clk);
            #1 mem_rdy = 1'b1; mem_data = e.data;
            @(posedge clk);
            #1 mem_rdy = 1'b0; mem_data = '0;
            @(negedge clk);
            model_data[e.layer] = e.data;
            n_cmp++;
            if (layer_rdy !== NL'(1 << e.layer)) begin
                n_err++;
                $display("FAIL layer_rdy: got %b required %b", layer_rdy, NL'(1 << e.layer));
            end
        end else begin
            k = 0;
            while (k < 80) begin
                @(negedge clk);
                k++;
                if (layer_err !== '0) break;
            end
            n_cmp++;
            if (k != 64) begin
                n_err++;
                $display("FAIL timeout_latency: got %0d cycles required 64", k);
            end
            n_cmp++;
            if (layer_err !== NL'(1 << e.layer)) begin
                n_err++;
                $display("FAIL layer_err: got %b required %b", layer_err, NL'(1 << e.layer));
            end
        end
        n_cmp++;
        if (layer_data !== model_packed()) begin
            n_err++;
            $display("FAIL layer_data: got %h required %h", layer_data, model_packed());
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        layer_req  = '0;
        layer_addr = '0;
        mem_rdy    = 1'b0;
        mem_data   = '0;
        for (int i = 0; i < NL; i++) model_data[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({mem_req, mem_addr, layer_data, layer_rdy, layer_err, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got req=%b addr=%h data=%h rdy=%b err=%b busy=%b required all 0",
                     mem_req, mem_addr, layer_data, layer_rdy, layer_err, busy);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        int cyc;
        drive_req(3'b010, '0, 21'h0ABCD, '0);
        push_exp(1, 21'h0ABCD, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL single_early_req: got %b required 0 one cycle after request", mem_req);
        end
        serve_one(5, cyc);
        n_cmp++;
        if (cyc != 1) begin
            n_err++;
            $display("FAIL single_latency: got %0d required 1 cycle after latch", cyc);
        end
        n_cmp++;
        if ({layer_data[DW-1:0], layer_data[2*DW +: DW]} !== '0) begin
            n_err++;
            $display("FAIL single_others: got %h/%h required 0/0", layer_data[DW-1:0], layer_data[2*DW +: DW]);
        end
    endtask

    task automatic test_simultaneous();
        int cyc;
        apply_reset();
        drive_req(3'b111, 21'h100, 21'h200, 21'h300);
        push_exp(0, 21'h100, 32'h1111_0000, 1'b0);
        push_exp(1, 21'h200, 32'h2222_0000, 1'b0);
        push_exp(2, 21'h300, 32'h3333_0000, 1'b0);
        serve_one(3, cyc);
        serve_one(1, cyc);
        serve_one(6, cyc);
    endtask

    task automatic test_fairness();
        int cyc;
        drive_req(3'b111, 21'h400, 21'h500, 21'h600);
        push_exp(0, 21'h400, 32'hA0A0_0001, 1'b0);
        push_exp(1, 21'h500, 32'hA1A1_0002, 1'b0);
        push_exp(2, 21'h600, 32'hA2A2_0003, 1'b0);
        serve_one(2, cyc);
        fork
            drive_req(3'b001, 21'h401, '0, '0);
        join_none
        push_exp(0, 21'h401, 32'hA0A0_0004, 1'b0);
        serve_one(2, cyc);
        serve_one(2, cyc);
        serve_one(2, cyc);
    endtask

    task automatic test_overwrite();
        int cyc;
        int extra;
        drive_req(3'b001, 21'h700, '0, '0);
        push_exp(0, 21'h700, 32'hB0B0_0700, 1'b0);
        push_exp(2, 21'h020, 32'hB2B2_0020, 1'b0);
        fork
            begin
                repeat (2) @(posedge clk);
                drive_req(3'b100, '0, '0, 21'h010);
                drive_req(3'b100, '0, '0, 21'h020);
            end
        join_none
        serve_one(8, cyc);
        serve_one(2, cyc);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL overwrite_extra_fetch: got %0d extra mem_req required 0", extra);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        int hits;
        drive_req(3'b110, '0, 21'h111, 21'h222);
        push_exp(1, 21'h111, '0, 1'b1);
        push_exp(2, 21'h222, 32'hCAFE_F00D, 1'b0);
        serve_one(0, cyc);
        serve_one(4, cyc);
        @(posedge clk);
        #1 mem_rdy = 1'b1; mem_data = 32'h1234_5678;
        @(posedge clk);
        #1 mem_rdy = 1'b0; mem_data = '0;
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (layer_rdy !== '0 || busy !== 1'b0) hits++;
        end
        n_cmp++;
        if (hits != 0) begin
            n_err++;
            $display("FAIL late_rdy_idle: got %0d reacting cycles required 0", hits);
        end
        n_cmp++;
        if (layer_data !== model_packed()) begin
            n_err++;
            $display("FAIL late_rdy_data: got %h required %h", layer_data, model_packed());
        end
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        int cyc;
        int hits;
        drive_req(3'b001, 21'h0AAA, '0, '0);
        wait_req(seen, cyc);
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL rst_wait_issue: got no mem_req required one");
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < NL; i++) model_data[i] = '0;
        n_cmp++;
        if ({mem_req, mem_addr, layer_data, layer_rdy, layer_err, busy} !== '0) begin
            n_err++;
            $display("FAIL rst_async: got req=%b addr=%h data=%h busy=%b required all 0",
                     mem_req, mem_addr, layer_data, busy);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1 mem_rdy = 1'b1; mem_data = 32'h5555_5555;
        @(posedge clk);
        #1 mem_rdy = 1'b0; mem_data = '0;
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (layer_rdy !== '0 || busy !== 1'b0 || mem_req !== 1'b0) hits++;
        end
        n_cmp++;
        if (hits != 0) begin
            n_err++;
            $display("FAIL rst_late_rdy: got %0d active cycles required 0", hits);
        end
        n_cmp++;
        if (layer_data !== '0) begin
            n_err++;
            $display("FAIL rst_data: got %h required 0", layer_data);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_overwrite();
        test_timeout();
        test_reset_mid_wait();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
